radix4_divider: RTL



---
 rtl/radix4_divider.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/radix4_divider.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_divider
//  Description : Iterative radix-4 integer divider (RISC-V DIV/DIVU/REM/REMU)
//                with valid/ready handshakes, early-out on short dividends.
//                Optional last-result cache: define RADIX4_DIVIDER_CACHE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module radix4_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam int              c_NW   = c_CW + 1;
    localparam logic [c_NW-1:0] c_HALF = c_NW'(WIDTH / 2);
    localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_PREP   = 2'd1;
    localparam logic [1:0] c_DIVIDE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]       r_state, w_next;
    logic [WIDTH-1:0] r_dvd, r_dvs;
    logic             r_signed, r_sign_q, r_sign_r;
    logic [WIDTH-1:0] r_rem, r_shift, r_quo;
    logic [WIDTH+1:0] r_d1, r_d2, r_d3;
    logic [c_NW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_quotient, r_remainder;

    logic [WIDTH-1:0] w_abs_dvd, w_abs_dvs;
    logic [c_CW-1:0]  w_msb;
    logic [c_NW-1:0]  w_n;
    logic [c_NW:0]    w_shamt;
    logic             w_div0, w_ovf, w_zero, w_special, w_hit;
    logic [WIDTH+1:0] w_trial;
    logic [1:0]       w_digit;
    logic [WIDTH-1:0] w_rem_next, w_q_next;
    logic             w_last, w_load;
    logic [WIDTH-1:0] w_res_q, w_res_r;

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (in_valid)              w_next = c_PREP;
            c_PREP:   w_next = (w_special || w_hit) ? c_DONE : c_DIVIDE;
            c_DIVIDE: if (w_last)                w_next = c_DONE;
            c_DONE:   if (out_ready)             w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == c_IDLE) && !rst;
        out_valid = (r_state == c_DONE);
    end

    // Operand magnitudes and the trimmed iteration count
    always_comb begin
        w_abs_dvd = (r_signed && r_dvd[WIDTH-1]) ? -r_dvd : r_dvd;
        w_abs_dvs = (r_signed && r_dvs[WIDTH-1]) ? -r_dvs : r_dvs;
        w_msb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_abs_dvd[i]) w_msb = c_CW'(i);
        end
        w_n     = ({1'b0, w_msb} + c_NW'(2)) >> 1;
        w_shamt = {c_HALF - w_n, 1'b0};
    end

    assign w_div0    = (r_dvs == '0);
    assign w_ovf     = r_signed && (r_dvd == c_MIN) && (r_dvs == '1);
    assign w_zero    = (w_abs_dvd == '0);
    assign w_special = w_div0 || w_ovf || w_zero;

    // One radix-4 step: pick the largest multiple that fits
    always_comb begin
        w_trial = {r_rem, r_shift[WIDTH-1:WIDTH-2]};
        if (w_trial >= r_d3) begin
            w_digit    = 2'd3;
            w_rem_next = w_trial[WIDTH-1:0] - r_d3[WIDTH-1:0];
        end else if (w_trial >= r_d2) begin
            w_digit    = 2'd2;
            w_rem_next = w_trial[WIDTH-1:0] - r_d2[WIDTH-1:0];
        end else if (w_trial >= r_d1) begin
            w_digit    = 2'd1;
            w_rem_next = w_trial[WIDTH-1:0] - r_d1[WIDTH-1:0];
        end else begin
            w_digit    = 2'd0;
            w_rem_next = w_trial[WIDTH-1:0];
        end
        w_q_next = (r_quo << 2) | {{(WIDTH-2){1'b0}}, w_digit};
    end

    assign w_last = (r_state == c_DIVIDE) && (r_cnt == c_NW'(1));

`ifdef RADIX4_DIVIDER_CACHE_EN
    logic             r_c_valid, r_c_sgn;
    logic [WIDTH-1:0] r_c_dvd, r_c_dvs, r_c_quo, r_c_rem;

    assign w_hit = r_c_valid && (r_c_dvd == r_dvd) && (r_c_dvs == r_dvs)
                   && (r_c_sgn == r_signed);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid <= 1'b0;
            r_c_sgn   <= 1'b0;
            r_c_dvd   <= '0;
            r_c_dvs   <= '0;
            r_c_quo   <= '0;
            r_c_rem   <= '0;
        end else if (w_load && !w_hit) begin
            r_c_valid <= 1'b1;
            r_c_sgn   <= r_signed;
            r_c_dvd   <= r_dvd;
            r_c_dvs   <= r_dvs;
            r_c_quo   <= w_res_q;
            r_c_rem   <= w_res_r;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // Final result selection, including the sign fix-up
    always_comb begin
        w_load  = 1'b0;
        w_res_q = w_q_next;
        w_res_r = w_rem_next;
        if (r_state == c_PREP) begin
            w_load = w_special || w_hit;
            if (w_hit) begin
`ifdef RADIX4_DIVIDER_CACHE_EN
                w_res_q = r_c_quo;
                w_res_r = r_c_rem;
`endif
            end else if (w_div0) begin
                w_res_q = '1;
                w_res_r = r_dvd;
            end else if (w_ovf) begin
                w_res_q = c_MIN;
                w_res_r = '0;
            end else begin
                w_res_q = '0;
                w_res_r = '0;
            end
        end else if (w_last) begin
            w_load  = 1'b1;
            w_res_q = r_sign_q ? -w_q_next : w_q_next;
            w_res_r = r_sign_r ? -w_rem_next : w_rem_next;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_signed    <= 1'b0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_rem       <= '0;
            r_shift     <= '0;
            r_quo       <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
            r_d3        <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            if (r_state == c_IDLE && in_valid) begin
                r_dvd    <= dividend;
                r_dvs    <= divisor;
                r_signed <= is_signed;
            end
            if (r_state == c_PREP) begin
                r_sign_q <= r_signed & (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]);
                r_sign_r <= r_signed & r_dvd[WIDTH-1];
                r_rem    <= '0;
                r_quo    <= '0;
                r_shift  <= w_abs_dvd << w_shamt;
                r_d1     <= {2'b00, w_abs_dvs};
                r_d2     <= {1'b0, w_abs_dvs, 1'b0};
                r_d3     <= {2'b00, w_abs_dvs} + {1'b0, w_abs_dvs, 1'b0};
                r_cnt    <= w_n;
            end
            if (r_state == c_DIVIDE) begin
                r_rem   <= w_rem_next;
                r_quo   <= w_q_next;
                r_shift <= r_shift << 2;
                r_cnt   <= r_cnt - c_NW'(1);
            end
            if (w_load) begin
                r_quotient  <= w_res_q;
                r_remainder <= w_res_r;
            end
        end
    end

endmodule
`default_nettype wire
